// File: rtl/demux32_stream_pkg.sv
// Shared defaults for the demux32_stream slice: word width, FIFO depth,
// counter width and the derived FIFO pointer width.
package demux32_stream_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 2;
  localparam int CNTW_DEF  = 16;
  localparam int PTR_W     = $clog2(DEPTH_DEF);

endpackage

// File: rtl/demux32_fifo.sv
// Synchronous FIFO with registered head output, full/empty flags and
// asynchronous active-low reset; one instance per demux output.
module demux32_fifo
  import demux32_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = PTR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Requests against a full or empty FIFO are ignored so occupancy can
  // neither overflow nor underflow.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/demux32_stream.sv
// 1-to-2 stream demultiplexer: routes each accepted word to one of two
// output FIFOs by `control` and counts accepted words per output.
module demux32_stream
  import demux32_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             control,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNTW-1:0]  out0_count,
  output logic [CNTW-1:0]  out1_count
);

  localparam int AW = $clog2(DEPTH);

  logic full0;
  logic full1;
  logic empty0;
  logic empty1;
  logic push0;
  logic push1;

  // Readiness looks only at the registered full flag of the selected FIFO,
  // so a same-cycle pop never opens the door early.
  assign in_ready   = rst_n && (control ? !full1 : !full0);
  assign push0      = in_valid && in_ready && !control;
  assign push1      = in_valid && in_ready && control;
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  demux32_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push0),
    .push_data(in_data),
    .pop      (out0_ready),
    .head_data(out0_data),
    .full     (full0),
    .empty    (empty0)
  );

  demux32_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push1),
    .push_data(in_data),
    .pop      (out1_ready),
    .head_data(out1_data),
    .full     (full1),
    .empty    (empty1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_count <= '0;
      out1_count <= '0;
    end else begin
      if (push0) out0_count <= out0_count + 1'b1;
      if (push1) out1_count <= out1_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux32_stream.sv
// Randomised and directed bench for demux32_stream against a queue-based
// reference model of the two output streams and their accept counters.
module tb_demux32_stream;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        control;
  logic [31:0] in_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
  logic [15:0] out0_count;
  logic [15:0] out1_count;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          cnt0;
  int          cnt1;
  int          checks;
  int          errors;
  logic        last_stall;

  demux32_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .control   (control),
    .in_data   (in_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out0_data (out0_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data),
    .out0_count(out0_count),
    .out1_count(out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, compare all outputs with the model mid-cycle, then
  // advance the model by whatever handshakes the model says occur.
  task automatic applyStimulus(input logic v, input logic c, input logic [31:0] d,
                               input logic r0, input logic r1);
    logic exp_ready;
    logic acc;
    logic pop0;
    logic pop1;
    in_valid   = v;
    control    = c;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    @(negedge clk);
    exp_ready = c ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    checkOutput("out0_valid", {31'b0, out0_valid}, {31'b0, q0.size() != 0});
    checkOutput("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
    if (q0.size() != 0) checkOutput("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) checkOutput("out1_data", out1_data, q1[0]);
    checkOutput("out0_count", {16'b0, out0_count}, cnt0);
    checkOutput("out1_count", {16'b0, out1_count}, cnt1);
    acc        = v && exp_ready;
    pop0       = r0 && (q0.size() != 0);
    pop1       = r1 && (q1.size() != 0);
    last_stall = v && !exp_ready;
    @(posedge clk);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (acc) begin
      if (c) begin
        q1.push_back(d);
        cnt1 = (cnt1 + 1) % 65536;
      end else begin
        q0.push_back(d);
        cnt0 = (cnt0 + 1) % 65536;
      end
    end
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    cnt0 = 0;
    cnt1 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic        v;
    logic        c;
    logic [31:0] d;
    checks     = 0;
    errors     = 0;
    cnt0       = 0;
    cnt1       = 0;
    last_stall = 1'b0;
    in_valid   = 1'b0;
    control    = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_out0_valid", {31'b0, out0_valid}, 32'd0);
    doReset();

    // Routing and latency with both consumers ready.
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("route_cnt0", {16'b0, out0_count}, 32'd1);
    checkOutput("route_cnt1", {16'b0, out1_count}, 32'd1);

    // Backpressure on out1, bypass to out0, then full-with-pop.
    doReset();
    applyStimulus(1'b1, 1'b1, 32'hA, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hB, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'hC, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hD, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'hD, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);

    // Reset mid-stream with FIFO1 holding two words.
    applyStimulus(1'b1, 1'b1, 32'h11, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h22, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out1_valid", {31'b0, out1_valid}, 32'd0);
    checkOutput("midrst_out1_count", {16'b0, out1_count}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    doReset();
    control = 1'b0;
    #1;
    checkOutput("rel_ready_c0", {31'b0, in_ready}, 32'd1);
    control = 1'b1;
    #1;
    checkOutput("rel_ready_c1", {31'b0, in_ready}, 32'd1);

    // Ten words through out0 with overlapping push and pop.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("ten_cnt0", {16'b0, out0_count}, 32'd10);

    // Randomised traffic honouring the hold-while-stalled rule.
    v = 1'b0;
    c = 1'b0;
    d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        v = ($urandom_range(0, 3) != 0);
        c = 1'($urandom_range(0, 1));
        d = $urandom;
      end
      applyStimulus(v, c, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
    end

    // Counter wrap: 65536 words to out0 from reset.
    doReset();
    for (int i = 0; i < 65536; i++) applyStimulus(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("wrap_cnt0", {16'b0, out0_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
